// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-core plus host arbiter for a shared single-port DRAM
//
// Purpose:
//   Serialises core 1 and core 2 load/store accesses onto one single-port
//   synchronous DRAM. The cores share it round-robin, one access per two
//   cycles. While ext_en is high the host owns the memory exclusively.
//
// Ports:
//   clock, reset_n               clock (rising edge), asynchronous active-low reset
//   c1_* / c2_*                  core request (req/we/addr/wdata), grant pulse,
//                                registered read data and its valid pulse
//   ext_en/ext_wr/ext_rd         host ownership request and access strobes
//   ext_addr/ext_wdata           host address and write data
//   ext_rdata/ext_ready          host read data (0 unless EXT) and ownership flag
//   mem_addr/mem_we/mem_wdata    DRAM command
//   mem_rdata                    DRAM read data, one cycle after the address edge
//   busy                         arbiter is not idle

module dram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,
  input  logic              c2_req,
  input  logic              c2_we,
  input  logic [ADDR_W-1:0] c2_addr,
  input  logic [DATA_W-1:0] c2_wdata,
  output logic              c2_gnt,
  output logic [DATA_W-1:0] c2_rdata,
  output logic              c2_rvalid,
  input  logic              ext_en,
  input  logic              ext_wr,
  input  logic              ext_rd,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_EXT    = 2'd3
  } state_t;

  state_t            state;
  logic              owner_c2;   // latched owner: 0 = core 1, 1 = core 2
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              favor_c1;   // round-robin preference, set when core 2 won last

  logic              any_req;
  logic              pick_c2;

  // Host reads are always enabled, so the read strobe carries no information here.
  logic              unused_ext_rd;
  assign unused_ext_rd = ext_rd;

  assign any_req = c1_req | c2_req;
  // Core 2 wins when it is the only requester, or when both request and core 1
  // was the last one granted.
  assign pick_c2 = c2_req & (~c1_req | ~favor_c1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      owner_c2  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      favor_c1  <= 1'b1;
      c1_gnt    <= 1'b0;
      c2_gnt    <= 1'b0;
      c1_rvalid <= 1'b0;
      c2_rvalid <= 1'b0;
      c1_rdata  <= '0;
      c2_rdata  <= '0;
    end else begin
      c1_gnt    <= 1'b0;
      c2_gnt    <= 1'b0;
      c1_rvalid <= 1'b0;
      c2_rvalid <= 1'b0;

      // Read data of the in-flight access is on mem_rdata during RESP.
      if (state == S_RESP && !lat_we) begin
        if (owner_c2) begin
          c2_rdata  <= mem_rdata;
          c2_rvalid <= 1'b1;
        end else begin
          c1_rdata  <= mem_rdata;
          c1_rvalid <= 1'b1;
        end
      end

      case (state)
        S_IDLE, S_RESP: begin
          // Arbitration point; host ownership takes precedence over cores.
          if (ext_en) begin
            state <= S_EXT;
          end else if (any_req) begin
            state     <= S_ACCESS;
            owner_c2  <= pick_c2;
            lat_we    <= pick_c2 ? c2_we    : c1_we;
            lat_addr  <= pick_c2 ? c2_addr  : c1_addr;
            lat_wdata <= pick_c2 ? c2_wdata : c1_wdata;
            favor_c1  <= pick_c2;
            c1_gnt    <= ~pick_c2;
            c2_gnt    <= pick_c2;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: state <= S_RESP;
        S_EXT:    if (!ext_en) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Memory command: latched core access in ACCESS/RESP (write only in ACCESS),
  // direct host pass-through in EXT, quiet otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ext_rdata = '0;
    case (state)
      S_ACCESS: begin
        mem_addr  = lat_addr;
        mem_we    = lat_we;
        mem_wdata = lat_wdata;
      end
      S_RESP: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      S_EXT: begin
        mem_addr  = ext_addr;
        mem_we    = ext_wr;
        mem_wdata = ext_wdata;
        ext_rdata = mem_rdata;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  assign ext_ready = (state == S_EXT);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter

module tb_dram_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clock;
  logic              reset_n;
  logic              c1_req, c1_we, c2_req, c2_we;
  logic [ADDR_W-1:0] c1_addr, c2_addr;
  logic [DATA_W-1:0] c1_wdata, c2_wdata;
  logic              c1_gnt, c2_gnt, c1_rvalid, c2_rvalid;
  logic [DATA_W-1:0] c1_rdata, c2_rdata;
  logic              ext_en, ext_wr, ext_rd;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic              ext_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  // DRAM model with a side preload port.
  logic [DATA_W-1:0] tb_mem [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  int total;
  int bad;
  logic seen;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_gnt(c1_gnt), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .c2_req(c2_req), .c2_we(c2_we), .c2_addr(c2_addr), .c2_wdata(c2_wdata),
    .c2_gnt(c2_gnt), .c2_rdata(c2_rdata), .c2_rvalid(c2_rvalid),
    .ext_en(ext_en), .ext_wr(ext_wr), .ext_rd(ext_rd), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ready(ext_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (pl_en)  tb_mem[pl_addr]  <= pl_data;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    c2_req = 0; c2_we = 0; c2_addr = '0; c2_wdata = '0;
    ext_en = 0; ext_wr = 0; ext_rd = 0; ext_addr = '0; ext_wdata = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // ---- reset values ----
    reset_n = 1'b0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    c2_req = 0; c2_we = 0; c2_addr = '0; c2_wdata = '0;
    ext_en = 0; ext_wr = 0; ext_rd = 0; ext_addr = '0; ext_wdata = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    tick();
    tick();
    check("rst_c1_gnt", c1_gnt, 0);
    check("rst_c2_gnt", c2_gnt, 0);
    check("rst_c1_rvalid", c1_rvalid, 0);
    check("rst_c2_rvalid", c2_rvalid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_c1_rdata", c1_rdata, 0);
    check("rst_c2_rdata", c2_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_ext_ready", ext_ready, 0);
    check("rst_busy", busy, 0);

    // ---- single c1 read of addr 5 ----
    do_reset();
    preload(9'd5, 16'h00AB);
    seen = 0;
    c1_req = 1; c1_we = 0; c1_addr = 9'd5;
    tick();
    check("t1_gnt", c1_gnt, 1);
    check("t1_maddr", mem_addr, 5);
    check("t1_mwe", mem_we, 0);
    seen = seen | c2_gnt | c2_rvalid | (|c2_rdata);
    c1_req = 0;
    tick();
    check("t1_gnt_off", c1_gnt, 0);
    check("t1_rvalid_early", c1_rvalid, 0);
    seen = seen | c2_gnt | c2_rvalid | (|c2_rdata);
    tick();
    check("t1_rvalid", c1_rvalid, 1);
    check("t1_rdata", c1_rdata, 16'h00AB);
    seen = seen | c2_gnt | c2_rvalid | (|c2_rdata);
    tick();
    check("t1_rvalid_pulse", c1_rvalid, 0);
    check("t1_rdata_hold", c1_rdata, 16'h00AB);
    check("t1_c2_quiet", seen, 0);
    check("t1_idle", busy, 0);

    // ---- simultaneous continuous requests ----
    do_reset();
    c1_req = 1; c1_we = 1; c1_addr = 9'd10; c1_wdata = 16'h1111;
    c2_req = 1; c2_we = 0; c2_addr = 9'd10;
    tick();
    check("t2_c1_first", c1_gnt, 1);
    check("t2_c2_wait", c2_gnt, 0);
    check("t2_mwe", mem_we, 1);
    check("t2_mwdata", mem_wdata, 16'h1111);
    tick();
    check("t2_resp_mwe", mem_we, 0);
    check("t2_resp_gnt", c1_gnt | c2_gnt, 0);
    tick();
    check("t2_c2_gnt", c2_gnt, 1);
    check("t2_c1_off", c1_gnt, 0);
    tick();
    tick();
    check("t2_c1_again", c1_gnt, 1);
    check("t2_c2_rvalid", c2_rvalid, 1);
    check("t2_c2_rdata", c2_rdata, 16'h1111);
    tick();
    tick();
    check("t2_c2_again", c2_gnt, 1);
    c1_req = 0; c2_req = 0;
    tick();
    tick();
    check("t2_c2_rvalid2", c2_rvalid, 1);
    check("t2_idle", busy, 0);

    // ---- host exclusive access ----
    do_reset();
    c1_req = 1; c1_we = 0; c1_addr = 9'd3;
    ext_en = 1;
    tick();
    check("t3_ready", ext_ready, 1);
    check("t3_busy", busy, 1);
    seen = c1_gnt;
    for (int i = 1; i <= 4; i++) begin
      ext_wr = 1; ext_addr = ADDR_W'(i); ext_wdata = DATA_W'(i);
      #1;
      check("t3_wr_we", mem_we, 1);
      check("t3_wr_addr", mem_addr, i);
      tick();
      seen = seen | c1_gnt;
    end
    ext_wr = 0;
    for (int i = 1; i <= 4; i++) begin
      ext_rd = 1; ext_addr = ADDR_W'(i);
      tick();
      check("t3_rd_data", ext_rdata, i);
      seen = seen | c1_gnt;
    end
    check("t3_no_c1_gnt", seen, 0);
    ext_en = 0; ext_rd = 0;
    tick();
    check("t3_exit_ready", ext_ready, 0);
    check("t3_exit_rdata", ext_rdata, 0);
    check("t3_exit_gnt", c1_gnt, 0);
    tick();
    check("t3_c1_gnt", c1_gnt, 1);
    c1_req = 0;
    tick();
    tick();
    check("t3_c1_rvalid", c1_rvalid, 1);
    check("t3_c1_rdata", c1_rdata, 3);

    // ---- ext_en rising during a c2 access ----
    do_reset();
    c2_req = 1; c2_we = 0; c2_addr = 9'd2;
    tick();
    check("t4_c2_gnt", c2_gnt, 1);
    c2_req = 0;
    ext_en = 1;
    c1_req = 1; c1_we = 0; c1_addr = 9'd1;
    tick();
    check("t4_resp_not_ext", ext_ready, 0);
    tick();
    check("t4_ext", ext_ready, 1);
    check("t4_c2_rvalid", c2_rvalid, 1);
    check("t4_c2_rdata", c2_rdata, 2);
    seen = c1_gnt;
    tick();
    seen = seen | c1_gnt;
    tick();
    seen = seen | c1_gnt;
    check("t4_c1_waits", seen, 0);
    ext_en = 0;
    tick();
    tick();
    check("t4_c1_gnt", c1_gnt, 1);
    c1_req = 0;
    tick();
    tick();
    check("t4_c1_rdata", c1_rdata, 1);

    // ---- reset during a c1 write ACCESS ----
    do_reset();
    preload(9'd7, 16'h1234);
    c1_req = 1; c1_we = 1; c1_addr = 9'd7; c1_wdata = 16'hBEEF;
    tick();
    check("t5_mwe_pre", mem_we, 1);
    check("t5_maddr_pre", mem_addr, 7);
    #2;
    reset_n = 0;
    #1;
    check("t5_mwe", mem_we, 0);
    check("t5_maddr", mem_addr, 0);
    check("t5_mwdata", mem_wdata, 0);
    check("t5_gnt", c1_gnt, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", ext_ready, 0);
    c1_req = 0;
    tick();
    reset_n = 1;
    tick();
    check("t5_mem7", tb_mem[7], 16'h1234);
    check("t5_rvalid", c1_rvalid, 0);
    check("t5_rdata", c1_rdata, 0);

    // ---- c2 pulse during RESP dropped before exit edge ----
    do_reset();
    c1_req = 1; c1_we = 0; c1_addr = 9'd4;
    tick();
    check("t6_c1_gnt", c1_gnt, 1);
    c1_req = 0;
    tick();
    c2_req = 1; c2_we = 0; c2_addr = 9'd9;
    #3;
    c2_req = 0;
    tick();
    check("t6_idle", busy, 0);
    check("t6_no_c2_gnt", c2_gnt, 0);
    check("t6_c1_rvalid", c1_rvalid, 1);
    check("t6_c1_rdata", c1_rdata, 4);
    tick();
    check("t6_still_idle", busy, 0);
    check("t6_no_c2_gnt2", c2_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard ceiling so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
